// File: rtl/data_cache.sv
// 2-way set-associative, write-back, write-allocate data cache for the memory stage.
// One 32-bit word per line; misses freeze the pipeline through CacheStall.
module data_cache #(
  parameter int SETS    = 256,
  parameter int WORDS_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MemReadM,
  input  logic               MemWriteM,
  input  logic [2:0]         AddressingControlM,
  input  logic [31:0]        ALUResultM,
  input  logic [31:0]        WriteDataM,
  output logic [31:0]        ReadDataM,
  output logic               CacheStall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [WORDS_W-1:0] mem_wdata,
  input  logic [WORDS_W-1:0] mem_rdata,
  input  logic               mem_ack
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  logic [WORDS_W-1:0] dataArr [2][SETS];
  logic [TAG_W-1:0]   tagArr  [2][SETS];
  logic [1:0][SETS-1:0] validQ, dirtyQ;
  logic [SETS-1:0]      lruQ;          // way to evict next
  logic [1:0]           state, stateNext;
  logic                 victimQ;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic             access, hit, hitSel, victimWay;
  logic [1:0]       hitWay;
  logic [1:0][WORDS_W-1:0] wayData;
  logic [WORDS_W-1:0] lineData, merged, wdRep;
  logic [3:0]         be;
  logic [31:0]        byteSh, halfSh, loadVal;

  assign idx    = ALUResultM[2+IDX_W-1:2];
  assign tag    = ALUResultM[31:2+IDX_W];
  assign off    = ALUResultM[1:0];
  assign access = MemReadM | MemWriteM;

  for (genvar w = 0; w < 2; w++) begin : gWay
    assign wayData[w] = dataArr[w][idx];
    assign hitWay[w]  = validQ[w][idx] && (tagArr[w][idx] == tag);
  end

  assign hit      = |hitWay;
  assign hitSel   = ~hitWay[0];
  assign lineData = wayData[hitSel];

  // Fill an empty way before displacing anything; way0 wins when both are empty.
  assign victimWay = !validQ[0][idx] ? 1'b0 :
                     !validQ[1][idx] ? 1'b1 : lruQ[idx];

  always_comb begin
    be    = 4'b1111;
    wdRep = WriteDataM;
    case (AddressingControlM[1:0])
      2'b00: begin be = 4'b0001 << off; wdRep = {4{WriteDataM[7:0]}}; end
      2'b01: begin be = off[1] ? 4'b1100 : 4'b0011; wdRep = {2{WriteDataM[15:0]}}; end
      default: ;
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : gLane
    assign merged[8*b +: 8] = be[b] ? wdRep[8*b +: 8] : lineData[8*b +: 8];
  end

  always_comb begin
    byteSh = lineData >> {off, 3'b000};
    halfSh = lineData >> {off[1], 4'b0000};
    case (AddressingControlM)
      3'b000:  loadVal = {{24{byteSh[7]}}, byteSh[7:0]};
      3'b001:  loadVal = {{16{halfSh[15]}}, halfSh[15:0]};
      3'b100:  loadVal = {24'b0, byteSh[7:0]};
      3'b101:  loadVal = {16'b0, halfSh[15:0]};
      default: loadVal = lineData;
    endcase
  end

  // Reset gating keeps the pipeline-facing outputs quiet even if the stage still drives an access.
  assign ReadDataM  = (rst && state == IDLE && MemReadM && !MemWriteM && hit) ? loadVal : 32'b0;
  assign CacheStall = rst & ((state != IDLE) | (access & ~hit));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (access && !hit)
                   stateNext = (validQ[victimWay][idx] && dirtyQ[victimWay][idx]) ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ack) stateNext = REFILL;
      REFILL:    if (mem_ack) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'b0;
    mem_wdata = '0;
    case (state)
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tagArr[victimQ][idx], idx, 2'b00};
        mem_wdata = dataArr[victimQ][idx];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {ALUResultM[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      validQ  <= '0;
      dirtyQ  <= '0;
      lruQ    <= '0;
      victimQ <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (access) begin
          if (hit) begin
            lruQ[idx] <= ~hitSel;
            if (MemWriteM) dirtyQ[hitSel][idx] <= 1'b1;
          end else begin
            victimQ <= victimWay;
          end
        end
        REFILL: if (mem_ack) begin
          validQ[victimQ][idx] <= 1'b1;
          dirtyQ[victimQ][idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (state == IDLE && access && hit && MemWriteM) begin
      dataArr[hitSel][idx] <= merged;
    end else if (state == REFILL && mem_ack) begin
      dataArr[victimQ][idx] <= mem_rdata;
      tagArr[victimQ][idx]  <= tag;
    end
  end
endmodule
